// File: rtl/ram_io_responder_if.sv
// rtl/ram_io_responder_if.sv - MemCtrl byte bus and UART stream signals of the RAM/IO responder
interface ram_io_responder_if;
   logic [31:0] mem_a;
   logic [7:0]  mem_write;
   logic        is_write;
   logic [7:0]  mem_result;
   logic        cannot_read;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        program_halt;

   modport master (
      output mem_a, mem_write, is_write, uart_tx_ready, uart_rx_data, uart_rx_valid,
      input  mem_result, cannot_read, uart_tx_data, uart_tx_valid, program_halt
   );

   modport slave (
      input  mem_a, mem_write, is_write, uart_tx_ready, uart_rx_data, uart_rx_valid,
      output mem_result, cannot_read, uart_tx_data, uart_tx_valid, program_halt
   );
endinterface

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte RAM plus UART TX/RX FIFO and halt register behind MemCtrl's bus
module ram_io_responder #(
   parameter int ADDR_WIDTH         = 17,
   parameter int FIFO_DEPTH_LOG     = 3,
   parameter int ALMOST_FULL_MARGIN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   ram_io_responder_if.slave bus
);
   localparam int PW    = FIFO_DEPTH_LOG;
   localparam int CW    = FIFO_DEPTH_LOG + 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] MARGIN_C = CW'(ALMOST_FULL_MARGIN);

   logic [7:0] ram    [0:(1<<ADDR_WIDTH)-1];
   logic [7:0] tx_mem [0:DEPTH-1];
   logic [7:0] rx_mem [0:DEPTH-1];

   logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0] tx_count, rx_count, tx_count_nxt, rx_count_nxt;
   logic [7:0]    mem_result_q;
   logic          cannot_read_q;
   logic          halt_q;

   logic                  is_io, io_data_sel, io_halt_sel;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic [15:0]           io_off;
   logic                  tx_full, tx_empty, rx_full, rx_empty;
   logic                  tx_push, tx_pop, rx_push, rx_pop;
   logic [7:0]            rd_data;
   logic                  unused_addr_bits;

   // Bits above the I/O select do not participate in decode; addresses alias.
   assign is_io            = (bus.mem_a[17:16] == 2'b11);
   assign ram_idx          = bus.mem_a[ADDR_WIDTH-1:0];
   assign io_off           = bus.mem_a[15:0];
   assign io_data_sel      = is_io && (io_off == 16'h0000);
   assign io_halt_sel      = is_io && (io_off == 16'h0004);
   assign unused_addr_bits = &{1'b0, bus.mem_a[31:18]};

   assign tx_full  = (tx_count == DEPTH_C);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == DEPTH_C);
   assign rx_empty = (rx_count == '0);

   // A push into a full FIFO is only accepted when the same cycle frees a slot.
   assign tx_pop  = rdy && !tx_empty && bus.uart_tx_ready;
   assign tx_push = rdy && bus.is_write && io_data_sel && (!tx_full || tx_pop);
   assign rx_pop  = rdy && !bus.is_write && io_data_sel && !rx_empty;
   assign rx_push = rdy && bus.uart_rx_valid && (!rx_full || rx_pop);

   assign tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
   assign rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);

   // Read mux: RAM byte, RX head, or RX status, depending on the decoded window.
   always_comb begin
      rd_data = 8'h00;
      if (!is_io) begin
         rd_data = ram[ram_idx];
      end else if (io_data_sel) begin
         rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      end else if (io_halt_sel) begin
         rd_data = {7'b0, !rx_empty};
      end
   end

   // Storage arrays are not reset; they only capture accepted writes and pushes.
   always_ff @(posedge clk) begin
      if (!rst && rdy && bus.is_write && !is_io) ram[ram_idx] <= bus.mem_write;
      if (!rst && tx_push) tx_mem[tx_wr_ptr] <= bus.mem_write;
      if (!rst && rx_push) rx_mem[rx_wr_ptr] <= bus.uart_rx_data;
   end

   // Control state: pointers, counts, read result, back-pressure and halt flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr     <= '0;
         tx_rd_ptr     <= '0;
         rx_wr_ptr     <= '0;
         rx_rd_ptr     <= '0;
         tx_count      <= '0;
         rx_count      <= '0;
         mem_result_q  <= 8'h00;
         cannot_read_q <= 1'b0;
         halt_q        <= 1'b0;
      end else if (rdy) begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
         tx_count      <= tx_count_nxt;
         rx_count      <= rx_count_nxt;
         mem_result_q  <= bus.is_write ? 8'h00 : rd_data;
         cannot_read_q <= ((DEPTH_C - tx_count_nxt) <= MARGIN_C);
         if (bus.is_write && io_halt_sel) halt_q <= 1'b1;
      end
   end

   assign bus.mem_result    = mem_result_q;
   assign bus.cannot_read   = cannot_read_q;
   assign bus.uart_tx_valid = !tx_empty;
   assign bus.uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
   assign bus.program_halt  = halt_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - scoreboard bench for ram_io_responder
module tb_ram_io_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   logic rd_issue = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] tx_q[$];

   ram_io_responder_if bus();

   ram_io_responder dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [7:0] data);
      bus.mem_a     = addr;
      bus.mem_write = data;
      bus.is_write  = 1'b1;
      cyc();
      bus.is_write  = 1'b0;
      bus.mem_a     = 32'h0;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [7:0] exp);
      bus.mem_a = addr;
      bus.is_write = 1'b0;
      rd_issue = 1'b1;
      exp_q.push_back(exp);
      cyc();
      rd_issue = 1'b0;
      bus.mem_a = 32'h0;
   endtask

   // Monitor: compares read results one cycle after issue, and each TX byte as it is drained.
   initial begin
      logic rd_pending;
      logic [7:0] e;
      rd_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_pending) begin
            if (exp_q.size() == 0) chk("rd_queue_empty", 32'h1, 32'h0);
            else begin
               e = exp_q.pop_front();
               chk("mem_result", {24'h0, bus.mem_result}, {24'h0, e});
            end
         end
         rd_pending = rd_issue && rdy && !rst;
         if (bus.uart_tx_valid && bus.uart_tx_ready && rdy && !rst) begin
            if (tx_q.size() == 0) chk("tx_unexpected", {24'h0, bus.uart_tx_data}, 32'hFFFF_FFFF);
            else begin
               e = tx_q.pop_front();
               chk("uart_tx_data", {24'h0, bus.uart_tx_data}, {24'h0, e});
            end
         end
      end
   end

   initial begin
      bus.mem_a = 32'h0;
      bus.mem_write = 8'h0;
      bus.is_write = 1'b0;
      bus.uart_tx_ready = 1'b0;
      bus.uart_rx_data = 8'h0;
      bus.uart_rx_valid = 1'b0;
      cyc();
      cyc();
      chk("rst_mem_result", {24'h0, bus.mem_result}, 32'h0);
      chk("rst_cannot_read", {31'h0, bus.cannot_read}, 32'h0);
      chk("rst_tx_valid", {31'h0, bus.uart_tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, bus.uart_tx_data}, 32'h0);
      chk("rst_halt", {31'h0, bus.program_halt}, 32'h0);
      rst = 1'b0;

      // RAM write/read, same-address readback next cycle, wrap and ignored upper bits
      wr(32'h0001_0, 8'hA5);
      rd(32'h0000_0010, 8'hA5);
      wr(32'h0000_0011, 8'h5A);
      rd(32'h0000_0010, 8'hA5);
      rd(32'h0000_0011, 8'h5A);
      rd(32'h0002_0010, 8'hA5);
      rd(32'h1234_0010, 8'hA5);

      // TX back-pressure with the UART stalled
      bus.uart_tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr(32'h0003_0000, 8'h41 + 8'(i));
         tx_q.push_back(8'h41 + 8'(i));
         if (i == 4) chk("cr_after_5_push", {31'h0, bus.cannot_read}, 32'h0);
      end
      chk("cr_after_6_push", {31'h0, bus.cannot_read}, 32'h1);
      chk("tx_valid_queued", {31'h0, bus.uart_tx_valid}, 32'h1);
      bus.uart_tx_ready = 1'b1;
      cyc();
      chk("cr_after_first_pop", {31'h0, bus.cannot_read}, 32'h0);
      for (int i = 0; i < 20 && bus.uart_tx_valid; i++) cyc();
      chk("tx_drained", {31'h0, bus.uart_tx_valid}, 32'h0);

      // TX overflow: ninth byte dropped, then push at full with a simultaneous pop
      bus.uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr(32'h0003_0000, 8'h50 + 8'(i));
         if (i < 8) tx_q.push_back(8'h50 + 8'(i));
      end
      chk("cr_full", {31'h0, bus.cannot_read}, 32'h1);
      chk("tx_head_full", {24'h0, bus.uart_tx_data}, 32'h50);
      bus.uart_tx_ready = 1'b1;
      wr(32'h0003_0000, 8'h59);
      tx_q.push_back(8'h59);
      chk("cr_push_pop_full", {31'h0, bus.cannot_read}, 32'h1);
      chk("tx_head_after_pp", {24'h0, bus.uart_tx_data}, 32'h51);
      for (int i = 0; i < 20 && bus.uart_tx_valid; i++) cyc();
      chk("tx_overflow_drained", {31'h0, bus.uart_tx_valid}, 32'h0);
      bus.uart_tx_ready = 1'b0;

      // RX path
      bus.uart_rx_valid = 1'b1;
      bus.uart_rx_data = 8'h31;
      cyc();
      bus.uart_rx_data = 8'h32;
      cyc();
      bus.uart_rx_valid = 1'b0;
      rd(32'h0003_0004, 8'h01);
      rd(32'h0003_0000, 8'h31);
      rd(32'h0003_0000, 8'h32);
      rd(32'h0003_0004, 8'h00);
      rd(32'h0003_0000, 8'h00);
      bus.uart_rx_valid = 1'b1;
      bus.uart_rx_data = 8'h77;
      rd(32'h0003_0000, 8'h00);
      bus.uart_rx_valid = 1'b0;
      rd(32'h0003_0000, 8'h77);
      rd(32'h0003_0008, 8'h00);

      // Halt register and rdy freeze
      chk("halt_before", {31'h0, bus.program_halt}, 32'h0);
      wr(32'h0003_0004, 8'h3C);
      chk("halt_set", {31'h0, bus.program_halt}, 32'h1);
      rd(32'h0000_0010, 8'hA5);
      rdy = 1'b0;
      wr(32'h0003_0000, 8'h99);
      chk("rdy0_mem_result_hold", {24'h0, bus.mem_result}, 32'hA5);
      chk("rdy0_no_push", {31'h0, bus.uart_tx_valid}, 32'h0);
      rdy = 1'b1;
      cyc();
      chk("halt_sticky", {31'h0, bus.program_halt}, 32'h1);

      // Reset in the middle of a TX drain
      for (int i = 0; i < 4; i++) wr(32'h0003_0000, 8'h61 + 8'(i));
      tx_q.push_back(8'h61);
      bus.uart_tx_ready = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();
      chk("mid_rst_tx_valid", {31'h0, bus.uart_tx_valid}, 32'h0);
      chk("mid_rst_cannot_read", {31'h0, bus.cannot_read}, 32'h0);
      chk("mid_rst_halt", {31'h0, bus.program_halt}, 32'h0);
      chk("mid_rst_mem_result", {24'h0, bus.mem_result}, 32'h0);
      rst = 1'b0;
      bus.uart_tx_ready = 1'b0;
      cyc();
      cyc();
      chk("rd_queue_drained", exp_q.size(), 32'h0);
      chk("tx_queue_drained", tx_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
